// File: rtl/ma_pkg.sv
// Shared types and constants for the moving-average crossover signal path.
package ma_pkg;

    localparam int unsigned PRICE_W = 10;
    localparam int unsigned DIFF_W  = 12;

    typedef enum logic [1:0] {
        FLAT  = 2'b00,
        LONG  = 2'b01,
        SHORT = 2'b10
    } position_t;

    localparam logic EVT_BUY  = 1'b1;
    localparam logic EVT_SELL = 1'b0;

endpackage

// File: rtl/ma_crossover_signal_if.sv
// Sample input, event output handshake and status signals of the crossover block.
interface ma_crossover_signal_if;
    import ma_pkg::*;

    logic [PRICE_W-1:0] price_in;
    logic [PRICE_W-1:0] avg_in;
    logic               in_valid;
    logic               evt_valid;
    logic               evt_type;
    logic [PRICE_W-1:0] evt_price;
    logic               evt_ready;
    logic [1:0]         position;
    logic               overflow;

    modport master (
        output price_in, avg_in, in_valid, evt_ready,
        input  evt_valid, evt_type, evt_price, position, overflow
    );

    modport slave (
        input  price_in, avg_in, in_valid, evt_ready,
        output evt_valid, evt_type, evt_price, position, overflow
    );
endinterface

// File: rtl/ma_evt_holdreg.sv
// Single-entry valid/ready event register; a new event arriving while full
// and not being consumed is dropped and latches the sticky overflow flag.
module ma_evt_holdreg
    import ma_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               load_type,
    input  logic [PRICE_W-1:0] load_price,
    input  logic               ready,
    output logic               valid,
    output logic               evt_type,
    output logic [PRICE_W-1:0] evt_price,
    output logic               overflow
);
    logic               valid_q, valid_d;
    logic               type_q, type_d;
    logic [PRICE_W-1:0] price_q, price_d;
    logic               ovf_q, ovf_d;
    logic               consume;

    assign consume = valid_q && ready;

    always_comb begin
        valid_d = valid_q;
        type_d  = type_q;
        price_d = price_q;
        ovf_d   = ovf_q;
        if (load) begin
            if (!valid_q || consume) begin
                valid_d = 1'b1;
                type_d  = load_type;
                price_d = load_price;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            type_q  <= 1'b0;
            price_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            type_q  <= type_d;
            price_q <= price_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid     = valid_q;
    assign evt_type  = type_q;
    assign evt_price = price_q;
    assign overflow  = ovf_q;
endmodule

// File: rtl/ma_crossover_signal.sv
// Price-vs-average crossover detector: hysteresis classification, warm-up
// discard, confirmation counting and FLAT/LONG/SHORT position tracking.
module ma_crossover_signal
    import ma_pkg::*;
#(
    parameter int unsigned THRESH  = 8,
    parameter int unsigned CONFIRM = 2,
    parameter int unsigned WARMUP  = 5
) (
    input logic                  clk,
    input logic                  reset,
    ma_crossover_signal_if.slave bus
);
    localparam logic signed [DIFF_W-1:0] THR    = DIFF_W'(THRESH);
    localparam logic [3:0]               CONF4  = 4'(CONFIRM);
    localparam logic [7:0]               WARM8  = 8'(WARMUP);

    logic signed [DIFF_W-1:0] diff;
    logic                     above, below;
    logic [7:0]               warm_q, warm_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     dir_q, dir_d;
    position_t                pos_q, pos_d;
    logic                     fire;
    logic                     fire_type;

    assign diff  = $signed({2'b00, bus.price_in}) - $signed({2'b00, bus.avg_in});
    assign above = diff > THR;
    assign below = diff < -THR;

    always_comb begin
        warm_d    = warm_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        pos_d     = pos_q;
        fire      = 1'b0;
        fire_type = EVT_SELL;
        if (bus.in_valid) begin
            if (warm_q < WARM8) begin
                warm_d = warm_q + 8'd1;
            end else if (!above && !below) begin
                cnt_d = '0;
            end else if ((above && pos_q == LONG) || (below && pos_q == SHORT)) begin
                cnt_d = '0;
            end else begin
                // dir_q is meaningful only while the count is non-zero
                if (cnt_q != 4'd0 && dir_q == above) begin
                    cnt_d = (cnt_q >= CONF4) ? CONF4 : cnt_q + 4'd1;
                end else begin
                    cnt_d = 4'd1;
                    dir_d = above;
                end
                if (cnt_d >= CONF4) begin
                    cnt_d     = '0;
                    fire      = 1'b1;
                    fire_type = above ? EVT_BUY : EVT_SELL;
                    pos_d     = above ? LONG : SHORT;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm_q <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            pos_q  <= FLAT;
        end else begin
            warm_q <= warm_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            pos_q  <= pos_d;
        end
    end

    assign bus.position = pos_q;

    ma_evt_holdreg u_holdreg (
        .clk        (clk),
        .reset      (reset),
        .load       (fire),
        .load_type  (fire_type),
        .load_price (bus.price_in),
        .ready      (bus.evt_ready),
        .valid      (bus.evt_valid),
        .evt_type   (bus.evt_type),
        .evt_price  (bus.evt_price),
        .overflow   (bus.overflow)
    );
endmodule

// File: tb/tb_ma_crossover_signal.sv
// Directed self-checking bench for ma_crossover_signal with default parameters.
module tb_ma_crossover_signal;
    logic clk;
    logic reset;
    int   cmp_cnt;
    int   err_cnt;
    logic [14:0] obs;

    ma_crossover_signal_if bus ();

    ma_crossover_signal #(.THRESH(8), .CONFIRM(2), .WARMUP(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {evt_valid, evt_type, evt_price[9:0], position[1:0], overflow}
    assign obs = {bus.evt_valid, bus.evt_type, bus.evt_price, bus.position, bus.overflow};

    function automatic logic [14:0] pack(input logic v, input logic t, input logic [9:0] p,
                                         input logic [1:0] pos, input logic o);
        return {v, t, p, pos, o};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.evt_ready = 1'b0;
        #3 reset = 1'b0;
    endtask

    task automatic sample(input logic [9:0] p, input logic [9:0] a);
        @(negedge clk);
        bus.price_in = p;
        bus.avg_in   = a;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic warmup();
        for (int i = 0; i < 5; i++) sample(10'd100, 10'd100);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        cmp_cnt++;
        if (obs !== pack(0, 0, 10'd0, 2'b00, 0)) begin
            err_cnt++;
            $display("FAIL reset_state: got %h expected %h", obs, pack(0, 0, 10'd0, 2'b00, 0));
        end
        #2 reset = 1'b0;
    endtask

    task automatic test_warmup();
        do_reset();
        for (int i = 0; i < 5; i++) sample(10'd200, 10'd100);
        cmp_cnt++;
        if (obs !== pack(0, 0, 10'd0, 2'b00, 0)) begin
            err_cnt++;
            $display("FAIL warmup_ignored: got %h expected %h", obs, pack(0, 0, 10'd0, 2'b00, 0));
        end
        sample(10'd120, 10'd100);
        cmp_cnt++;
        if (obs !== pack(0, 0, 10'd0, 2'b00, 0)) begin
            err_cnt++;
            $display("FAIL warmup_first_count: got %h expected %h", obs, pack(0, 0, 10'd0, 2'b00, 0));
        end
        sample(10'd120, 10'd100);
        cmp_cnt++;
        if (obs !== pack(1, 1, 10'd120, 2'b01, 0)) begin
            err_cnt++;
            $display("FAIL warmup_buy: got %h expected %h", obs, pack(1, 1, 10'd120, 2'b01, 0));
        end
    endtask

    task automatic test_hysteresis();
        do_reset();
        warmup();
        for (int i = 0; i < 4; i++) sample(10'd108, 10'd100);
        cmp_cnt++;
        if (obs !== pack(0, 0, 10'd0, 2'b00, 0)) begin
            err_cnt++;
            $display("FAIL hyst_plus_edge: got %h expected %h", obs, pack(0, 0, 10'd0, 2'b00, 0));
        end
        for (int i = 0; i < 3; i++) sample(10'd92, 10'd100);
        cmp_cnt++;
        if (obs !== pack(0, 0, 10'd0, 2'b00, 0)) begin
            err_cnt++;
            $display("FAIL hyst_minus_edge: got %h expected %h", obs, pack(0, 0, 10'd0, 2'b00, 0));
        end
        sample(10'd109, 10'd100);
        sample(10'd109, 10'd100);
        cmp_cnt++;
        if (obs !== pack(1, 1, 10'd109, 2'b01, 0)) begin
            err_cnt++;
            $display("FAIL hyst_buy: got %h expected %h", obs, pack(1, 1, 10'd109, 2'b01, 0));
        end
    endtask

    task automatic test_gap();
        do_reset();
        warmup();
        sample(10'd80, 10'd100);
        sample(10'd97, 10'd100);
        sample(10'd80, 10'd100);
        cmp_cnt++;
        if (obs !== pack(0, 0, 10'd0, 2'b00, 0)) begin
            err_cnt++;
            $display("FAIL gap_interrupted: got %h expected %h", obs, pack(0, 0, 10'd0, 2'b00, 0));
        end
        repeat (3) @(posedge clk);
        #1;
        sample(10'd80, 10'd100);
        cmp_cnt++;
        if (obs !== pack(1, 0, 10'd80, 2'b10, 0)) begin
            err_cnt++;
            $display("FAIL gap_sell: got %h expected %h", obs, pack(1, 0, 10'd80, 2'b10, 0));
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        warmup();
        sample(10'd120, 10'd100);
        sample(10'd120, 10'd100);
        sample(10'd80, 10'd100);
        sample(10'd80, 10'd100);
        cmp_cnt++;
        if (obs !== pack(1, 1, 10'd120, 2'b10, 1)) begin
            err_cnt++;
            $display("FAIL bp_overflow: got %h expected %h", obs, pack(1, 1, 10'd120, 2'b10, 1));
        end
        @(negedge clk);
        bus.evt_ready = 1'b1;
        @(posedge clk);
        #1 bus.evt_ready = 1'b0;
        cmp_cnt++;
        if (obs !== pack(0, 1, 10'd120, 2'b10, 1)) begin
            err_cnt++;
            $display("FAIL bp_drain: got %h expected %h", obs, pack(0, 1, 10'd120, 2'b10, 1));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        warmup();
        sample(10'd80, 10'd100);
        sample(10'd80, 10'd100);
        cmp_cnt++;
        if (obs !== pack(1, 0, 10'd80, 2'b10, 0)) begin
            err_cnt++;
            $display("FAIL b2b_sell: got %h expected %h", obs, pack(1, 0, 10'd80, 2'b10, 0));
        end
        sample(10'd121, 10'd100);
        bus.evt_ready = 1'b1;
        sample(10'd121, 10'd100);
        bus.evt_ready = 1'b0;
        cmp_cnt++;
        if (obs !== pack(1, 1, 10'd121, 2'b01, 0)) begin
            err_cnt++;
            $display("FAIL b2b_buy: got %h expected %h", obs, pack(1, 1, 10'd121, 2'b01, 0));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        warmup();
        sample(10'd120, 10'd100);
        sample(10'd120, 10'd100);
        #2 reset = 1'b1;
        #1;
        cmp_cnt++;
        if (obs !== pack(0, 0, 10'd0, 2'b00, 0)) begin
            err_cnt++;
            $display("FAIL mid_reset_async: got %h expected %h", obs, pack(0, 0, 10'd0, 2'b00, 0));
        end
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample(10'd120, 10'd100);
            cmp_cnt++;
            if (obs !== pack(0, 0, 10'd0, 2'b00, 0)) begin
                err_cnt++;
                $display("FAIL mid_reset_warm%0d: got %h expected %h", i, obs, pack(0, 0, 10'd0, 2'b00, 0));
            end
        end
        sample(10'd130, 10'd100);
        sample(10'd130, 10'd100);
        cmp_cnt++;
        if (obs !== pack(1, 1, 10'd130, 2'b01, 0)) begin
            err_cnt++;
            $display("FAIL mid_reset_rebuy: got %h expected %h", obs, pack(1, 1, 10'd130, 2'b01, 0));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        cmp_cnt       = 0;
        err_cnt       = 0;
        reset         = 1'b0;
        bus.price_in  = '0;
        bus.avg_in    = '0;
        bus.in_valid  = 1'b0;
        bus.evt_ready = 1'b0;
        test_reset();
        test_warmup();
        test_hysteresis();
        test_gap();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
